// File: rtl/ext_ram_arbiter.sv
// ext_ram_arbiter: round-robin arbiter that shares one single-port, sync-read RAM between
// NUM_REQ decoder units. It supports bounded burst locking and tags read data to its requester.
module ext_ram_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int MAX_LOCK   = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ-1:0]            req_we,
  input  logic [NUM_REQ-1:0]            req_lock,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [NUM_REQ-1:0]            rvalid,
  output logic [DATA_WIDTH-1:0]         rdata,
  output logic                          ram_cs,
  output logic                          ram_we,
  output logic [ADDR_WIDTH-1:0]         ram_address,
  output logic [DATA_WIDTH-1:0]         ram_data_in,
  input  logic [DATA_WIDTH-1:0]         ram_data_out
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_LOCK + 1);
  localparam logic [CNT_W-1:0] LOCK_MAX = CNT_W'(MAX_LOCK);
  localparam logic [PTR_W-1:0] LAST_REQ = PTR_W'(NUM_REQ - 1);

  typedef enum logic {ST_ARB, ST_LOCKED} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [PTR_W-1:0]   r_rr_ptr;
  logic [PTR_W-1:0]   w_rr_ptr_nxt;
  logic [PTR_W-1:0]   r_owner;
  logic [PTR_W-1:0]   w_owner_nxt;
  logic [CNT_W-1:0]   r_lock_cnt;
  logic [CNT_W-1:0]   w_lock_cnt_nxt;
  logic [NUM_REQ-1:0] r_rvalid;
  logic [NUM_REQ-1:0] w_gnt;
  logic               w_hold;

  logic               w_lo_found;
  logic [PTR_W-1:0]   w_lo_idx;
  logic               w_hi_found;
  logic [PTR_W-1:0]   w_hi_idx;
  logic               w_arb_found;
  logic [PTR_W-1:0]   w_arb_idx;

  // Lowest requester at or above rr_ptr wins; otherwise the search wraps to the lowest overall.
  always_comb begin
    w_lo_found = 1'b0;
    w_lo_idx   = '0;
    w_hi_found = 1'b0;
    w_hi_idx   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req[k]) begin
        w_lo_found = 1'b1;
        w_lo_idx   = PTR_W'(k);
        if (k >= int'(r_rr_ptr)) begin
          w_hi_found = 1'b1;
          w_hi_idx   = PTR_W'(k);
        end
      end
    end
    w_arb_found = w_lo_found;
    w_arb_idx   = w_hi_found ? w_hi_idx : w_lo_idx;
  end

  // A lock is kept only while the owner still requests, still locks and has budget left.
  assign w_hold = (r_state == ST_LOCKED) && req[r_owner] && req_lock[r_owner] &&
                  (r_lock_cnt != LOCK_MAX);

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    w_gnt          = '0;
    w_state_nxt    = ST_ARB;
    w_rr_ptr_nxt   = r_rr_ptr;
    w_owner_nxt    = r_owner;
    w_lock_cnt_nxt = '0;
    if (!reset) begin
      if (w_hold) begin
        w_gnt[r_owner] = 1'b1;
        w_state_nxt    = ST_LOCKED;
        w_lock_cnt_nxt = r_lock_cnt + CNT_W'(1);
      end else if (w_arb_found) begin
        w_gnt[w_arb_idx] = 1'b1;
        w_rr_ptr_nxt     = (w_arb_idx == LAST_REQ) ? '0 : w_arb_idx + PTR_W'(1);
        if (req_lock[w_arb_idx]) begin
          w_state_nxt    = ST_LOCKED;
          w_owner_nxt    = w_arb_idx;
          w_lock_cnt_nxt = CNT_W'(1);
        end
      end
    end
  end

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_ARB;
      r_rr_ptr   <= '0;
      r_owner    <= '0;
      r_lock_cnt <= '0;
      r_rvalid   <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_rr_ptr   <= w_rr_ptr_nxt;
      r_owner    <= w_owner_nxt;
      r_lock_cnt <= w_lock_cnt_nxt;
      r_rvalid   <= w_gnt & ~req_we;
    end
  end

  always_comb begin
    ram_we      = 1'b0;
    ram_address = '0;
    ram_data_in = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (w_gnt[k]) begin
        ram_we      = req_we[k];
        ram_address = req_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
        ram_data_in = req_wdata[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign gnt    = w_gnt;
  assign ram_cs = |w_gnt;
  // A read tag still in flight when reset rises is suppressed immediately, not one edge later.
  assign rvalid = r_rvalid & ~{NUM_REQ{reset}};
  assign rdata  = ram_data_out;

endmodule

// File: tb/tb_ext_ram_arbiter.sv
// tb_ext_ram_arbiter: directed scenarios plus randomized traffic. A rule-level reference model
// feeds a scoreboard, and a separate monitor compares each cycle's grant, RAM pins and read returns.
module tb_ext_ram_arbiter;

  localparam int N  = 2;
  localparam int DW = 8;
  localparam int AW = 8;
  localparam int ML = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  req, req_we, req_lock;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N-1:0]  gnt, rvalid;
  logic [DW-1:0] rdata;
  logic          ram_cs, ram_we;
  logic [AW-1:0] ram_address;
  logic [DW-1:0] ram_data_in, ram_data_out;

  typedef struct {
    logic [N-1:0]  gnt;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [N-1:0]  rvalid;
  } exp_t;

  typedef struct {
    int            who;
    logic [DW-1:0] data;
  } rd_t;

  exp_t exp_q[$];
  rd_t  rd_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  ext_ram_arbiter #(
    .NUM_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_LOCK(ML)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .req_we(req_we), .req_lock(req_lock),
    .req_addr(req_addr), .req_wdata(req_wdata), .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
    .ram_cs(ram_cs), .ram_we(ram_we), .ram_address(ram_address), .ram_data_in(ram_data_in),
    .ram_data_out(ram_data_out)
  );

  always #5 clk = ~clk;

  // External RAM: single port, synchronous read with one cycle of latency.
  logic [DW-1:0] ram_mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (ram_cs) begin
      if (ram_we) ram_mem[ram_address] <= ram_data_in;
      else        ram_data_out <= ram_mem[ram_address];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic logic [N-1:0] onehot(input int i);
    logic [N-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // Reference model: arbitration rules as plain integers plus a shadow of the RAM contents.
  logic [DW-1:0] shadow [0:(1<<AW)-1];
  bit            m_locked    = 1'b0;
  int            m_owner     = 0;
  int            m_cnt       = 0;
  int            m_ptr       = 0;
  logic [N-1:0]  m_pend      = '0;
  int            m_pend_who  = 0;
  logic [DW-1:0] m_pend_data = '0;
  logic [N-1:0]  m_last_gnt  = '0;

  task automatic model_step();
    exp_t e;
    int   g;
    e.rvalid = reset ? '0 : m_pend;
    if (!reset && m_pend != '0) rd_q.push_back('{who: m_pend_who, data: m_pend_data});
    g = -1;
    if (reset) begin
      m_locked = 1'b0;
      m_ptr    = 0;
      m_cnt    = 0;
    end else if (m_locked && req[m_owner] && req_lock[m_owner] && m_cnt < ML) begin
      g = m_owner;
      m_cnt++;
    end else begin
      m_locked = 1'b0;
      for (int d = 0; d < N; d++)
        if (g < 0 && req[(m_ptr + d) % N]) g = (m_ptr + d) % N;
      if (g >= 0) begin
        m_ptr = (g + 1) % N;
        if (req_lock[g]) begin
          m_locked = 1'b1;
          m_owner  = g;
          m_cnt    = 1;
        end
      end
    end
    e.gnt   = '0;
    e.we    = 1'b0;
    e.addr  = '0;
    e.wdata = '0;
    m_pend  = '0;
    if (g >= 0) begin
      e.gnt[g] = 1'b1;
      e.we     = req_we[g];
      e.addr   = req_addr[g*AW +: AW];
      e.wdata  = req_wdata[g*DW +: DW];
      if (e.we) begin
        shadow[e.addr] = e.wdata;
      end else begin
        m_pend      = onehot(g);
        m_pend_who  = g;
        m_pend_data = shadow[e.addr];
      end
    end
    m_last_gnt = e.gnt;
    exp_q.push_back(e);
  endtask

  always @(posedge clk) begin
    #2;
    model_step();
  end

  // Monitor: pops one expectation per cycle and a read record whenever the DUT raises rvalid.
  exp_t mon_e;
  rd_t  mon_r;
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      check("gnt", 32'(gnt), 32'(mon_e.gnt));
      check("ram_cs", 32'(ram_cs), 32'(|mon_e.gnt));
      check("ram_we", 32'(ram_we), 32'(mon_e.we));
      check("ram_address", 32'(ram_address), 32'(mon_e.addr));
      check("ram_data_in", 32'(ram_data_in), 32'(mon_e.wdata));
      check("rvalid", 32'(rvalid), 32'(mon_e.rvalid));
      if (rvalid != '0) begin
        if (rd_q.size() == 0) begin
          check("rvalid_unexpected", 32'(rvalid), 32'h0);
        end else begin
          mon_r = rd_q.pop_front();
          check("rvalid_owner", 32'(rvalid), 32'(onehot(mon_r.who)));
          check("rdata", 32'(rdata), 32'(mon_r.data));
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic drive(input int i, input logic r, input logic we, input logic lk,
                       input logic [AW-1:0] a, input logic [DW-1:0] d);
    req[i]              = r;
    req_we[i]           = we;
    req_lock[i]         = lk;
    req_addr[i*AW +: AW]  = a;
    req_wdata[i*DW +: DW] = d;
  endtask

  task automatic idle_all();
    for (int i = 0; i < N; i++) drive(i, 1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  int b_left [N];

  initial begin
    logic [N-1:0] seq4 [6];
    seq4[0] = 2'b01; seq4[1] = 2'b01; seq4[2] = 2'b01;
    seq4[3] = 2'b01; seq4[4] = 2'b10; seq4[5] = 2'b01;
    for (int i = 0; i < N; i++) b_left[i] = 0;

    // Reset with both requesters active: nothing may be granted.
    reset = 1'b1;
    drive(0, 1'b1, 1'b0, 1'b0, 8'h01, 8'h00);
    drive(1, 1'b1, 1'b0, 1'b0, 8'h02, 8'h00);
    for (int k = 0; k < 2; k++) begin
      at_neg();
      check("t1_gnt_in_reset", 32'(gnt), 32'h0);
      check("t1_cs_in_reset", 32'(ram_cs), 32'h0);
      check("t1_rvalid_in_reset", 32'(rvalid), 32'h0);
      cyc();
    end
    reset = 1'b0;
    at_neg();
    check("t1_first_gnt", 32'(gnt), 32'h1);
    cyc();
    at_neg();
    check("t1_second_gnt", 32'(gnt), 32'h2);

    // Write by requester 0, read back by requester 1.
    cyc();
    drive(0, 1'b1, 1'b1, 1'b0, 8'h05, 8'hA5);
    drive(1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    at_neg();
    check("t2_write_gnt", 32'(gnt), 32'h1);
    cyc();
    drive(0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    drive(1, 1'b1, 1'b0, 1'b0, 8'h05, 8'h00);
    at_neg();
    check("t2_read_gnt", 32'(gnt), 32'h2);
    cyc();
    idle_all();
    at_neg();
    check("t2_rvalid", 32'(rvalid), 32'h2);
    check("t2_rdata", 32'(rdata), 32'hA5);

    // Continuous reads from both: strict alternation, rvalid lags by one cycle.
    cyc();
    drive(0, 1'b1, 1'b0, 1'b0, 8'h05, 8'h00);
    drive(1, 1'b1, 1'b0, 1'b0, 8'h06, 8'h00);
    for (int k = 0; k < 8; k++) begin
      if (k > 0) cyc();
      at_neg();
      check("t3_alt_gnt", 32'(gnt), (k % 2 == 0) ? 32'h1 : 32'h2);
      if (k > 0) check("t3_rvalid_lag", 32'(rvalid), (k % 2 == 1) ? 32'h1 : 32'h2);
    end

    // Requester 0 locked with a budget of ML grants while requester 1 waits.
    cyc();
    drive(0, 1'b1, 1'b0, 1'b1, 8'h10, 8'h00);
    drive(1, 1'b1, 1'b0, 1'b0, 8'h11, 8'h00);
    for (int k = 0; k < 6; k++) begin
      if (k > 0) cyc();
      at_neg();
      check("t4_lock_gnt", 32'(gnt), 32'(seq4[k]));
    end
    cyc();
    idle_all();

    // Reset in the cycle after a read grant: the read return is lost and rr_ptr restarts.
    cyc();
    drive(0, 1'b1, 1'b0, 1'b0, 8'h05, 8'h00);
    at_neg();
    check("t5_read_gnt", 32'(gnt), 32'h1);
    cyc();
    reset = 1'b1;
    idle_all();
    at_neg();
    check("t5_rvalid_in_reset", 32'(rvalid), 32'h0);
    cyc();
    reset = 1'b0;
    drive(0, 1'b1, 1'b0, 1'b0, 8'h05, 8'h00);
    drive(1, 1'b1, 1'b0, 1'b0, 8'h06, 8'h00);
    at_neg();
    check("t5_rvalid_after_reset", 32'(rvalid), 32'h0);
    check("t5_ptr_restart_gnt", 32'(gnt), 32'h1);
    cyc();
    idle_all();

    // Sole requester drops its lock mid-burst: grants continue without a gap.
    cyc();
    drive(1, 1'b1, 1'b0, 1'b1, 8'h07, 8'h00);
    for (int k = 0; k < 6; k++) begin
      if (k > 0) cyc();
      if (k == 3) req_lock[1] = 1'b0;
      at_neg();
      check("t6_no_idle_gnt", 32'(gnt), 32'h2);
    end
    cyc();
    idle_all();

    // Preload the addresses used by random traffic so every read returns defined data.
    for (int a = 0; a < 16; a++) begin
      cyc();
      drive(0, 1'b1, 1'b1, 1'b0, AW'(a), DW'($urandom_range(0, 255)));
    end
    cyc();
    idle_all();

    // Random traffic with locks, bursts and occasional reset pulses.
    for (int c = 0; c < 3000; c++) begin
      cyc();
      reset = ($urandom_range(0, 63) == 0);
      for (int i = 0; i < N; i++) begin
        if (!req[i] || m_last_gnt[i]) begin
          if (b_left[i] > 0) begin
            b_left[i]--;
            req[i]      = ($urandom_range(0, 15) != 0);
            req_lock[i] = req[i] && ($urandom_range(0, 9) != 0);
          end else begin
            req[i]      = ($urandom_range(0, 3) != 0);
            req_lock[i] = req[i] && ($urandom_range(0, 4) == 0);
            if (req_lock[i]) b_left[i] = $urandom_range(1, 8);
          end
          req_we[i]             = 1'($urandom_range(0, 1));
          req_addr[i*AW +: AW]  = AW'($urandom_range(0, 15));
          req_wdata[i*DW +: DW] = DW'($urandom_range(0, 255));
        end
      end
    end

    cyc();
    reset = 1'b0;
    idle_all();
    repeat (4) cyc();
    check("rd_q_drained", 32'(rd_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
